ffra_wb_responder: RTL

Wishbone classic slave that lets the management SoC drive the `ffra` datapath instead of the IO pads. It holds the operand registers feeding `ffra` (`a`, `b`, `ci`), waits a fixed pipeline latency after each operand write, captures `o` into a result register, and reports completion through a status bit and an optional interrupt. It sits inside the user-project wrapper, between the `wbs_*` bus and the `ffra` instance.

---
 rtl/ffra_pkg.sv | 24 ++
 rtl/ffra_wb_if.sv | 51 +++++
 rtl/ffra_wb_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ffra_pkg.sv
// Shared definitions for the ffra Wishbone responder: register offsets, field
// bit positions and the compute FSM state type.
package ffra_pkg;

  // Word offsets (address bits [3:2]) inside the 16-byte register window
  localparam logic [1:0] FFRA_OFF_OPERAND = 2'd0;
  localparam logic [1:0] FFRA_OFF_RESULT  = 2'd1;
  localparam logic [1:0] FFRA_OFF_STATUS  = 2'd2;
  localparam logic [1:0] FFRA_OFF_CONTROL = 2'd3;

  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_DONE    = 1;
  localparam int CONTROL_IRQ_EN = 0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ffra_state_t;

  function automatic logic [3:0] ffra_offset_onehot(input logic [1:0] off);
    return 4'b0001 << off;
  endfunction

endpackage

// File: rtl/ffra_wb_if.sv
// Wishbone classic front end: address decode, single-cycle ack generation and
// per-offset one-hot read/write enables for the register file in the top.
module ffra_wb_if
  import ffra_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb_i,
  input  logic        cyc_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] adr_i,
  output logic        ack_o,
  output logic [3:0]  wr_en_o,
  output logic [3:0]  rd_en_o,
  output logic [3:0]  sel_o
);

  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFF0;

  logic       ack_q;
  logic       ack_d;
  logic       hit;
  logic       req;
  logic [3:0] off_hot;

  // A request is only accepted while no ack is outstanding, so a held strobe
  // alternates ack / no-ack.
  always_comb begin
    hit     = (adr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);
    req     = stb_i & cyc_i & hit & ~ack_q;
    off_hot = ffra_offset_onehot(adr_i[3:2]);
    ack_d   = req;
    wr_en_o = (req && we_i)  ? off_hot : 4'b0000;
    rd_en_o = (req && !we_i) ? off_hot : 4'b0000;
    sel_o   = sel_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
    end
  end

  assign ack_o = ack_q;

endmodule

// File: rtl/ffra_wb_responder.sv
// Wishbone slave that holds the ffra operands, waits a fixed pipeline latency
// after each operand write and captures the ffra result with done/irq status.
module ffra_wb_responder
  import ffra_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  a_o,
  output logic [7:0]  b_o,
  output logic [15:0] ci_o,
  input  logic [15:0] o_i,
  output logic        irq_o
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  logic [3:0]  wr_en;
  logic [3:0]  rd_en;
  logic [3:0]  sel;

  ffra_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] ci_q, ci_d;
  logic [15:0] result_q, result_d;
  logic        done_q, done_d;
  logic        irq_en_q, irq_en_d;
  logic [31:0] dat_q, dat_d;

  logic        op_start;
  logic        status_clr;
  logic        busy;
  logic        capture;

  ffra_wb_if #(
    .BASE_ADDR (BASE_ADDR)
  ) u_wb_if (
    .clk     (clk),
    .rst     (rst),
    .stb_i   (wbs_stb_i),
    .cyc_i   (wbs_cyc_i),
    .we_i    (wbs_we_i),
    .sel_i   (wbs_sel_i),
    .adr_i   (wbs_adr_i),
    .ack_o   (wbs_ack_o),
    .wr_en_o (wr_en),
    .rd_en_o (rd_en),
    .sel_o   (sel)
  );

  // An OPERAND write with no byte lanes selected is acked but starts nothing
  assign op_start   = wr_en[FFRA_OFF_OPERAND] & (|sel);
  assign status_clr = wr_en[FFRA_OFF_STATUS] & sel[0] & wbs_dat_i[STATUS_DONE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A new operand write restarts the count from any state, including the
  // capture edge itself.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (op_start) begin
      state_d = BUSY;
      cnt_d   = LAT;
    end else if (state_q == BUSY) begin
      if (cnt_q == 4'd0) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_comb begin
    busy    = (state_q == BUSY);
    capture = busy && (cnt_q == 4'd0) && !op_start;
  end

  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    ci_d = ci_q;
    if (wr_en[FFRA_OFF_OPERAND]) begin
      if (sel[0]) a_d        = wbs_dat_i[7:0];
      if (sel[1]) b_d        = wbs_dat_i[15:8];
      if (sel[2]) ci_d[7:0]  = wbs_dat_i[23:16];
      if (sel[3]) ci_d[15:8] = wbs_dat_i[31:24];
    end

    result_d = capture ? o_i : result_q;

    // Setting done on the capture edge takes priority over a same-edge clear
    done_d = done_q;
    if (op_start) begin
      done_d = 1'b0;
    end else if (capture) begin
      done_d = 1'b1;
    end else if (status_clr) begin
      done_d = 1'b0;
    end

    irq_en_d = irq_en_q;
    if (wr_en[FFRA_OFF_CONTROL] && sel[0]) begin
      irq_en_d = wbs_dat_i[CONTROL_IRQ_EN];
    end
  end

  // Read data is built from pre-edge register state and only held for the ack cycle
  always_comb begin
    dat_d = 32'h0;
    if (rd_en[FFRA_OFF_OPERAND]) begin
      dat_d = {ci_q, b_q, a_q};
    end
    if (rd_en[FFRA_OFF_RESULT]) begin
      dat_d = {16'h0, result_q};
    end
    if (rd_en[FFRA_OFF_STATUS]) begin
      dat_d[STATUS_BUSY] = busy;
      dat_d[STATUS_DONE] = done_q;
    end
    if (rd_en[FFRA_OFF_CONTROL]) begin
      dat_d[CONTROL_IRQ_EN] = irq_en_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= 8'h0;
      b_q      <= 8'h0;
      ci_q     <= 16'h0;
      result_q <= 16'h0;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
      dat_q    <= 32'h0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      ci_q     <= ci_d;
      result_q <= result_d;
      done_q   <= done_d;
      irq_en_q <= irq_en_d;
      dat_q    <= dat_d;
    end
  end

  assign a_o       = a_q;
  assign b_o       = b_q;
  assign ci_o      = ci_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = done_q & irq_en_q;

endmodule
